// File: rtl/vcol_pkg.sv
// Shared types and constants for the vector-column writeback arbiter.
package vcol_pkg;

    localparam int COL_W = 32;
    localparam int NCOLS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester not granted last
// wins; a lone requester is always granted.
module rr_arbiter2
    import vcol_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant from the valid pair and the index granted last time
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/vcol_wb_arbiter.sv
// Arbitrates two vector writeback requesters onto a single column-wide
// register-file write port, issuing each accepted vector as a 4-column burst.
//
// state | meaning
// IDLE  | no burst in flight, col_* outputs hold their last values
// BURST | writing buffered vector, one column per cycle, col_idx ascending
module vcol_wb_arbiter #(
    parameter int COL_W = vcol_pkg::COL_W,
    parameter int NCOLS = vcol_pkg::NCOLS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [NCOLS*COL_W-1:0] req0_data,
    input  logic [4:0]             req0_vrd,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [NCOLS*COL_W-1:0] req1_data,
    input  logic [4:0]             req1_vrd,
    output logic                   req1_ready,
    output logic                   col_we,
    output logic [1:0]             col_idx,
    output logic [4:0]             col_vrd,
    output logic [COL_W-1:0]       col_data,
    output logic                   busy,
    output logic                   stall0,
    output logic                   stall1
);

    import vcol_pkg::*;

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             cnt;
    logic [NCOLS*COL_W-1:0] buf_data;
    logic [4:0]             buf_vrd;
    logic                   last_grant;
    logic [1:0]             valid_vec;
    logic [1:0]             grant;
    logic                   window;
    logic                   xfer;
    logic [COL_W-1:0]       buf_cols [NCOLS];

    assign valid_vec = {req1_valid, req0_valid};

    rr_arbiter2 u_rr (
        .valid      (valid_vec),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // A new vector may be accepted when idle or while the last column is out,
    // which lets back-to-back bursts run without a gap. Readies are gated by
    // rst_n so nothing is accepted while reset is held.
    assign window     = (state == IDLE) || (cnt == 2'd3);
    assign req0_ready = rst_n & window & grant[0];
    assign req1_ready = rst_n & window & grant[1];
    assign xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // State register; async reset drops col_we immediately mid-burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: enter/stay in BURST on a transfer, leave after column 3
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = BURST;
            BURST:   if ((cnt == 2'd3) && !xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the granted vector and step the column counter. The counter
    // parks at 3 when the burst ends so the outputs keep the last column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            buf_data   <= '0;
            buf_vrd    <= 5'd0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            cnt        <= 2'd0;
            buf_data   <= req1_ready ? req1_data : req0_data;
            buf_vrd    <= req1_ready ? req1_vrd : req0_vrd;
            last_grant <= req1_ready;
        end else if ((state == BURST) && (cnt != 2'd3)) begin
            cnt <= cnt + 2'd1;
        end
    end

    for (genvar k = 0; k < NCOLS; k++) begin : g_cols
        assign buf_cols[k] = buf_data[k*COL_W +: COL_W];
    end

    assign col_we   = (state == BURST);
    assign busy     = (state == BURST);
    assign col_idx  = cnt;
    assign col_vrd  = buf_vrd;
    assign col_data = buf_cols[cnt];
    assign stall0   = req0_valid & ~req0_ready;
    assign stall1   = req1_valid & ~req1_ready;

endmodule
